// File: rtl/alignment_pkg.sv
// Shared types, state/mode encodings and saturating arithmetic for the alignment search engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alignment_pkg;

  // Search FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t SEARCH = 2'd1;
  localparam state_t DONE   = 2'd2;

  // Cost function selector
  typedef logic mode_t;
  localparam mode_t LINEAR     = 1'b0;
  localparam mode_t TRIANGULAR = 1'b1;

  // All saturating arithmetic is carried out at this width, then clipped to a caller limit
  localparam int SAT_W = 64;

  // a+b clipped to lim; the extra carry bit means the sum itself can never wrap
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                              input logic [SAT_W-1:0] b,
                                              input logic [SAT_W-1:0] lim);
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, lim}) return lim;
    return s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/alignment_cost_unit.sv
// LANES-wide cost of entries against candidate p (|x-p| or d*(d+1)/2), saturating lane sum.
// Latency: combinational.
// Backpressure: none; disabled lanes contribute zero.
module alignment_cost_unit #(
  parameter int POS_W  = 16,
  parameter int LANES  = 1,
  parameter int COST_W = 32
) (
  input  logic [LANES*POS_W-1:0] i_pos,
  input  logic [LANES-1:0]       i_lane_en,
  input  logic [POS_W-1:0]       i_p,
  input  logic                   i_mode,
  output logic [COST_W-1:0]      o_sum
);
  import alignment_pkg::*;

  localparam int TW = 2 * POS_W + 1;
  localparam logic [SAT_W-1:0] C_LIM = {SAT_W{1'b1}} >> (SAT_W - COST_W);

  logic [SAT_W-1:0] w_lane_cost [LANES];
  logic [SAT_W-1:0] w_sum;

  for (genvar g_l = 0; g_l < LANES; g_l++) begin : g_lane
    logic [POS_W-1:0] w_x;
    logic [POS_W-1:0] w_d;
    logic [TW-1:0]    w_dw;
    logic [TW-1:0]    w_tri;
    assign w_x   = i_pos[g_l*POS_W +: POS_W];
    assign w_d   = (w_x >= i_p) ? (w_x - i_p) : (i_p - w_x);
    assign w_dw  = TW'(w_d);
    // d*(d+1) always fits in TW bits, so the halving is exact
    assign w_tri = (w_dw * (w_dw + TW'(1))) >> 1;
    assign w_lane_cost[g_l] = !i_lane_en[g_l]        ? '0 :
                              (i_mode == TRIANGULAR) ? SAT_W'(w_tri) : SAT_W'(w_d);
  end

  // Saturating reduction; a single lane cost above the limit also clips here
  always_comb begin
    w_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sum = sat_add(w_sum, w_lane_cost[l], C_LIM);
    end
  end

  assign o_sum = COST_W'(w_sum);

endmodule

// File: rtl/alignment_search_engine.sv
// Loads positions, then sweeps every candidate in [min,max] for least total cost.
// Latency: finish C*B+2 clocks after start (C candidates, B beats each); empty set finishes next clock.
// Backpressure: in_ready low when storage full or not in IDLE; start/clear/in_valid ignored in SEARCH.
module alignment_search_engine #(
  parameter int POS_W  = 16,
  parameter int MAX_N  = 1024,
  parameter int LANES  = 1,
  parameter int COST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POS_W-1:0]  in_data,
  input  logic              clear,
  input  logic              mode,
  input  logic              start,
  output logic              busy,
  output logic              finish,
  output logic              empty_err,
  output logic [COST_W-1:0] solution,
  output logic [POS_W-1:0]  best_pos,
  output logic [31:0]       cycles
);
  import alignment_pkg::*;

  localparam int IDX_W = $clog2(MAX_N);
  localparam int CNT_W = IDX_W + 1;
  localparam int LOG_L = $clog2(LANES);
  localparam int BEATS = MAX_N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [SAT_W-1:0] C_LIM = {SAT_W{1'b1}} >> (SAT_W - COST_W);

  logic [POS_W-1:0]  r_mem [MAX_N];
  state_t            r_state;
  mode_t             r_mode;
  logic [CNT_W-1:0]  r_count;
  logic [POS_W-1:0]  r_min, r_max, r_p;
  logic [BW-1:0]     r_beat;
  logic              r_issue;
  logic              r_stage_vld, r_stage_last, r_stage_final;
  logic [COST_W-1:0] r_stage_sum;
  logic [POS_W-1:0]  r_stage_p;
  logic [COST_W-1:0] r_acc;
  logic              r_cand_vld, r_cand_final;
  logic [COST_W-1:0] r_cand;
  logic [POS_W-1:0]  r_cand_p;
  logic [COST_W-1:0] r_best;
  logic [POS_W-1:0]  r_best_pos;
  logic [COST_W-1:0] r_solution;
  logic [POS_W-1:0]  r_best_out;
  logic              r_empty_err;
  logic [31:0]       r_cycles;

  logic [LANES*POS_W-1:0] w_pos_bus;
  logic [LANES-1:0]       w_lane_en;
  logic [COST_W-1:0]      w_lane_sum;
  logic [CNT_W-1:0]       w_nbeats;
  logic [BW-1:0]          w_last_beat;
  logic                   w_beat_last, w_p_last, w_wr_en, w_cand_better;
  logic [COST_W-1:0]      w_acc_next;

  // Lane l of beat b reads entry b*LANES+l; entries at or beyond count are masked off
  for (genvar g_l = 0; g_l < LANES; g_l++) begin : g_rd
    logic [CNT_W-1:0] w_idx;
    assign w_idx = CNT_W'(r_beat) * CNT_W'(LANES) + CNT_W'(g_l);
    assign w_lane_en[g_l] = (w_idx < r_count);
    assign w_pos_bus[g_l*POS_W +: POS_W] = r_mem[w_idx[IDX_W-1:0]];
  end

  alignment_cost_unit #(
    .POS_W (POS_W),
    .LANES (LANES),
    .COST_W(COST_W)
  ) u_cost (
    .i_pos    (w_pos_bus),
    .i_lane_en(w_lane_en),
    .i_p      (r_p),
    .i_mode   (r_mode),
    .o_sum    (w_lane_sum)
  );

  assign in_ready      = (r_count < CNT_W'(MAX_N)) && (r_state == IDLE);
  // clear and start both take priority over a beat arriving in the same cycle
  assign w_wr_en       = in_valid && in_ready && !clear && !start;
  assign w_nbeats      = (r_count + CNT_W'(LANES - 1)) >> LOG_L;
  assign w_last_beat   = BW'(w_nbeats - CNT_W'(1));
  assign w_beat_last   = (r_beat == w_last_beat);
  assign w_p_last      = (r_p == r_max);
  assign w_acc_next    = COST_W'(sat_add(SAT_W'(r_acc), SAT_W'(r_stage_sum), C_LIM));
  // Strict compare: an equal later candidate never displaces an earlier one
  assign w_cand_better = (r_cand < r_best);

  assign busy      = (r_state == SEARCH);
  assign finish    = (r_state == DONE);
  assign empty_err = r_empty_err;
  assign solution  = r_solution;
  assign best_pos  = r_best_out;
  assign cycles    = r_cycles;

  // Position storage write port; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_count[IDX_W-1:0]] <= in_data;
  end

  // Control FSM, load bookkeeping and the issue -> stage -> accumulate -> compare pipeline
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_mode        <= LINEAR;
      r_count       <= '0;
      r_min         <= '0;
      r_max         <= '0;
      r_p           <= '0;
      r_beat        <= '0;
      r_issue       <= 1'b0;
      r_stage_vld   <= 1'b0;
      r_stage_last  <= 1'b0;
      r_stage_final <= 1'b0;
      r_stage_sum   <= '0;
      r_stage_p     <= '0;
      r_acc         <= '0;
      r_cand_vld    <= 1'b0;
      r_cand_final  <= 1'b0;
      r_cand        <= '0;
      r_cand_p      <= '0;
      r_best        <= '0;
      r_best_pos    <= '0;
      r_solution    <= '0;
      r_best_out    <= '0;
      r_empty_err   <= 1'b0;
      r_cycles      <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (clear) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_min       <= '0;
            r_max       <= '0;
            r_empty_err <= 1'b0;
          end else if (start) begin
            r_mode      <= mode;
            r_cycles    <= '0;
            r_empty_err <= (r_count == '0);
            if (r_count == '0) begin
              r_state    <= DONE;
              r_solution <= '0;
              r_best_out <= '0;
            end else begin
              r_state     <= SEARCH;
              r_p         <= r_min;
              r_beat      <= '0;
              r_issue     <= 1'b1;
              r_stage_vld <= 1'b0;
              r_acc       <= '0;
              r_cand_vld  <= 1'b0;
              r_best      <= '1;
              // Reported if every candidate saturates and nothing beats all-ones
              r_best_pos  <= r_min;
            end
          end else if (w_wr_en) begin
            r_count <= r_count + CNT_W'(1);
            if (r_count == '0 || in_data < r_min) r_min <= in_data;
            if (r_count == '0 || in_data > r_max) r_max <= in_data;
          end
        end
        SEARCH: begin
          r_cycles <= r_cycles + 32'd1;
          // Issue one beat of the current candidate into the stage register
          r_stage_vld <= r_issue;
          if (r_issue) begin
            r_stage_sum   <= w_lane_sum;
            r_stage_p     <= r_p;
            r_stage_last  <= w_beat_last;
            r_stage_final <= w_beat_last && w_p_last;
            if (w_beat_last) begin
              r_beat <= '0;
              if (w_p_last) r_issue <= 1'b0;
              else          r_p     <= r_p + POS_W'(1);
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
          // Accumulate beats; hand a finished candidate total to the compare stage
          r_cand_vld <= r_stage_vld && r_stage_last;
          if (r_stage_vld) begin
            if (r_stage_last) begin
              r_acc        <= '0;
              r_cand       <= w_acc_next;
              r_cand_p     <= r_stage_p;
              r_cand_final <= r_stage_final;
            end else begin
              r_acc <= w_acc_next;
            end
          end
          // Keep the running minimum; the final candidate also publishes the result
          if (r_cand_vld) begin
            if (w_cand_better) begin
              r_best     <= r_cand;
              r_best_pos <= r_cand_p;
            end
            if (r_cand_final) begin
              r_state    <= DONE;
              r_solution <= w_cand_better ? r_cand   : r_best;
              r_best_out <= w_cand_better ? r_cand_p : r_best_pos;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alignment_search_engine.sv
// Directed bench: u0 (1 lane) and u1 (4 lanes) share stimulus; u2 is a 16-bit-cost instance for saturation.
module tb_alignment_search_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  // shared stimulus for u0/u1
  logic        vld = 1'b0, clr = 1'b0, md = 1'b0, st = 1'b0;
  logic [15:0] dat = '0;
  // u2 stimulus
  logic        vld2 = 1'b0, clr2 = 1'b0, md2 = 1'b0, st2 = 1'b0;
  logic [15:0] dat2 = '0;

  logic        rdy0, busy0, fin0, err0, rdy1, busy1, fin1, err1, rdy2, busy2, fin2, err2;
  logic [31:0] sol0, sol1, cyc0, cyc1, cyc2;
  logic [15:0] sol2, pos0, pos1, pos2;

  int n_checks = 0;
  int n_fail   = 0;

  alignment_search_engine #(.POS_W(16), .MAX_N(16), .LANES(1), .COST_W(32)) u0 (
    .clk(clk), .reset(rst_n), .in_valid(vld), .in_ready(rdy0), .in_data(dat),
    .clear(clr), .mode(md), .start(st), .busy(busy0), .finish(fin0), .empty_err(err0),
    .solution(sol0), .best_pos(pos0), .cycles(cyc0));

  alignment_search_engine #(.POS_W(16), .MAX_N(16), .LANES(4), .COST_W(32)) u1 (
    .clk(clk), .reset(rst_n), .in_valid(vld), .in_ready(rdy1), .in_data(dat),
    .clear(clr), .mode(md), .start(st), .busy(busy1), .finish(fin1), .empty_err(err1),
    .solution(sol1), .best_pos(pos1), .cycles(cyc1));

  alignment_search_engine #(.POS_W(16), .MAX_N(4), .LANES(4), .COST_W(16)) u2 (
    .clk(clk), .reset(rst_n), .in_valid(vld2), .in_ready(rdy2), .in_data(dat2),
    .clear(clr2), .mode(md2), .start(st2), .busy(busy2), .finish(fin2), .empty_err(err2),
    .solution(sol2), .best_pos(pos2), .cycles(cyc2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_a(input logic [15:0] v);
    vld = 1'b1; dat = v;
    tick();
    vld = 1'b0;
  endtask

  task automatic pulse_clear_a();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Start u0/u1 together and measure clocks from the start edge to finish
  task automatic run_a(input string tag, input logic m, input int e_cyc0, input int e_cyc1,
                       input logic [31:0] e_sol, input logic [15:0] e_pos);
    int n, c0, c1;
    md = m; st = 1'b1;
    tick();
    st = 1'b0;
    check({tag, "_busy"}, 64'(busy0), 64'd1);
    check({tag, "_rdy_search"}, 64'(rdy0), 64'd0);
    n = 0; c0 = -1; c1 = -1;
    while ((c0 < 0 || c1 < 0) && n < 3000) begin
      if (fin0 && c0 < 0) c0 = n;
      if (fin1 && c1 < 0) c1 = n;
      if (c0 < 0 || c1 < 0) begin
        tick();
        n++;
      end
    end
    check({tag, "_lat0"}, 64'(c0), 64'(e_cyc0));
    check({tag, "_lat1"}, 64'(c1), 64'(e_cyc1));
    check({tag, "_cyc0"}, 64'(cyc0), 64'(e_cyc0));
    check({tag, "_cyc1"}, 64'(cyc1), 64'(e_cyc1));
    check({tag, "_sol0"}, 64'(sol0), 64'(e_sol));
    check({tag, "_sol1"}, 64'(sol1), 64'(e_sol));
    check({tag, "_pos0"}, 64'(pos0), 64'(e_pos));
    check({tag, "_pos1"}, 64'(pos1), 64'(e_pos));
    check({tag, "_err0"}, 64'(err0), 64'd0);
  endtask

  task automatic run_b(input string tag, input logic m, input int e_cyc,
                       input logic [15:0] e_sol, input logic [15:0] e_pos);
    int n;
    md2 = m; st2 = 1'b1;
    tick();
    st2 = 1'b0;
    n = 0;
    while (!fin2 && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(e_cyc));
    check({tag, "_cyc"}, 64'(cyc2), 64'(e_cyc));
    check({tag, "_sol"}, 64'(sol2), 64'(e_sol));
    check({tag, "_pos"}, 64'(pos2), 64'(e_pos));
  endtask

  logic [15:0] data1 [10] = '{16'd16, 16'd1, 16'd2, 16'd0, 16'd4, 16'd2, 16'd7, 16'd1, 16'd2, 16'd14};
  logic [15:0] data2 [4]  = '{16'd0, 16'd700, 16'd0, 16'd700};

  initial begin
    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_rdy",  64'(rdy0),  64'd1);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_fin",  64'(fin0),  64'd0);
    check("rst_err",  64'(err0),  64'd0);
    check("rst_sol",  64'(sol0),  64'd0);
    check("rst_pos",  64'(pos0),  64'd0);
    check("rst_cyc",  64'(cyc0),  64'd0);

    // Linear, then triangular twice from DONE without reloading; C=17, B=10 (1 lane) / 3 (4 lanes)
    for (int i = 0; i < 10; i++) load_a(data1[i]);
    run_a("lin", 1'b0, 172, 53, 32'd37, 16'd2);
    run_a("tri", 1'b1, 172, 53, 32'd168, 16'd5);
    run_a("tri_rerun", 1'b1, 172, 53, 32'd168, 16'd5);

    // clear from DONE: back to IDLE, outputs kept
    pulse_clear_a();
    check("clr_fin", 64'(fin0), 64'd0);
    check("clr_rdy", 64'(rdy0), 64'd1);
    check("clr_sol_kept", 64'(sol0), 64'd168);

    // Tie across all candidates: lowest p wins
    load_a(16'd0);
    load_a(16'd2);
    run_a("tie", 1'b0, 8, 5, 32'd2, 16'd0);

    // Fill to capacity, extra beat refused
    pulse_clear_a();
    for (int i = 0; i < 16; i++) load_a(16'd3);
    check("full_rdy0", 64'(rdy0), 64'd0);
    check("full_rdy1", 64'(rdy1), 64'd0);
    load_a(16'd100);
    run_a("full", 1'b0, 18, 6, 32'd0, 16'd3);

    // Start with nothing loaded
    pulse_clear_a();
    st = 1'b1;
    tick();
    st = 1'b0;
    check("empty_fin",  64'(fin0),  64'd1);
    check("empty_err0", 64'(err0),  64'd1);
    check("empty_err1", 64'(err1),  64'd1);
    check("empty_sol",  64'(sol0),  64'd0);
    check("empty_pos",  64'(pos0),  64'd0);
    check("empty_busy", 64'(busy0), 64'd0);

    // Reset in the middle of a search
    pulse_clear_a();
    load_a(16'd16);
    load_a(16'd0);
    md = 1'b0; st = 1'b1;
    tick();
    st = 1'b0;
    repeat (5) tick();
    check("mid_busy", 64'(busy0), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid_busy", 64'(busy0), 64'd0);
    check("rstmid_fin",  64'(fin0),  64'd0);
    check("rstmid_rdy",  64'(rdy0),  64'd1);
    check("rstmid_cyc",  64'(cyc0),  64'd0);
    repeat (60) tick();
    check("rstmid_nofin", 64'(fin0), 64'd0);
    st = 1'b1;
    tick();
    st = 1'b0;
    check("rstmid_count0", 64'(err0), 64'd1);

    // clear and start together: clear wins
    pulse_clear_a();
    load_a(16'd4);
    load_a(16'd5);
    clr = 1'b1; st = 1'b1;
    tick();
    clr = 1'b0; st = 1'b0;
    check("clrst_busy", 64'(busy0), 64'd0);
    check("clrst_fin",  64'(fin0),  64'd0);
    st = 1'b1;
    tick();
    st = 1'b0;
    check("clrst_cleared", 64'(err0), 64'd1);

    // Saturation on a 16-bit cost instance: every candidate exceeds 65535
    for (int i = 0; i < 4; i++) begin
      vld2 = 1'b1; dat2 = data2[i];
      tick();
    end
    vld2 = 1'b0;
    check("sat_full_rdy", 64'(rdy2), 64'd0);
    run_b("sat_tri", 1'b1, 703, 16'hFFFF, 16'd0);
    run_b("sat_lin", 1'b0, 703, 16'd1400, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
